// File: rtl/gondola_request_queue_pkg.sv
// Shared definitions for the gondola lock request queue: side encoding,
// default sizing and small arithmetic helpers.
package lock_pkg;

  typedef enum logic {
    SIDE_OUTER = 1'b0,
    SIDE_INNER = 1'b1
  } side_e;

  localparam int unsigned DEPTH_DEFAULT         = 4;
  localparam int unsigned ARRIVAL_DELAY_DEFAULT = 10;
  localparam int unsigned COUNT_W               = 4;
  localparam int unsigned ETA_W                 = 8;

  function automatic logic [ETA_W-1:0] sat_dec(input logic [ETA_W-1:0] v);
    return (v == '0) ? v : v - ETA_W'(1);
  endfunction

endpackage

// File: rtl/gondola_request_queue_if.sv
// Signal bundle between the arrival switches / lock controller and the
// request queue. The queue itself uses the slave view.
interface gondola_request_queue_if;
  import lock_pkg::*;

  logic               outer_gondola_arrival_sw;
  logic               inner_gondola_arrival_sw;
  logic               req_accept;
  logic               req_valid;
  logic               req_side;
  logic [COUNT_W-1:0] pending_count;
  logic [ETA_W-1:0]   head_eta;
  logic               full;
  logic               overflow;

  modport master (
    output outer_gondola_arrival_sw, inner_gondola_arrival_sw, req_accept,
    input  req_valid, req_side, pending_count, head_eta, full, overflow
  );

  modport slave (
    input  outer_gondola_arrival_sw, inner_gondola_arrival_sw, req_accept,
    output req_valid, req_side, pending_count, head_eta, full, overflow
  );

endinterface

// File: rtl/gondola_request_queue_rise_detect.sv
// One-cycle rising-edge detector for a pre-synchronised level switch.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);

  logic hist_q;

  // History follows the live level in reset too, so a switch already high
  // at reset release is not seen as a fresh edge.
  always_ff @(posedge clk) begin
    hist_q <= level_i;
  end

  assign rise_o = level_i & ~hist_q & ~reset;

endmodule

// File: rtl/gondola_request_queue.sv
// FIFO of gondola arrival requests (one side bit per entry) with a head
// arrival timer that gates the grant to the lock controller.
module gondola_request_queue
  import lock_pkg::*;
#(
  parameter int unsigned DEPTH         = DEPTH_DEFAULT,
  parameter int unsigned ARRIVAL_DELAY = ARRIVAL_DELAY_DEFAULT
) (
  input logic                    clk,
  input logic                    reset,
  gondola_request_queue_if.slave bus
);

  localparam int unsigned        PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] DEPTH_C  = COUNT_W'(DEPTH);
  localparam logic [ETA_W-1:0]   DELAY_C  = ETA_W'(ARRIVAL_DELAY);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  side_e              side_mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [ETA_W-1:0]   timer_q, timer_d;
  logic               overflow_q, overflow_d;

  logic               rise_outer, rise_inner;
  logic               req_valid, deq, enq_outer, enq_inner, head_load;
  logic [COUNT_W-1:0] free_slots;
  logic [PTR_W-1:0]   inner_wr_ptr;

  rise_detect u_rise_outer (
    .clk     (clk),
    .reset   (reset),
    .level_i (bus.outer_gondola_arrival_sw),
    .rise_o  (rise_outer)
  );

  rise_detect u_rise_inner (
    .clk     (clk),
    .reset   (reset),
    .level_i (bus.inner_gondola_arrival_sw),
    .rise_o  (rise_inner)
  );

  assign req_valid = (count_q != '0) && (timer_q == '0);

  always_comb begin
    deq        = req_valid & bus.req_accept;
    // A slot freed by this cycle's dequeue is usable by this cycle's enqueue.
    free_slots = DEPTH_C - count_q + COUNT_W'(deq);
    enq_outer  = rise_outer && (free_slots != '0);
    enq_inner  = rise_inner && (free_slots > COUNT_W'(enq_outer));

    inner_wr_ptr = enq_outer ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    wr_ptr_d     = enq_inner ? ptr_inc(inner_wr_ptr) : inner_wr_ptr;
    rd_ptr_d     = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d      = count_q - COUNT_W'(deq) + COUNT_W'(enq_outer) + COUNT_W'(enq_inner);

    head_load  = ((count_q == '0) && (enq_outer || enq_inner)) || (deq && (count_d != '0));
    timer_d    = head_load ? DELAY_C : sat_dec(timer_q);
    overflow_d = overflow_q | (rise_outer & ~enq_outer) | (rise_inner & ~enq_inner);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry contents need no reset: count_q alone decides what is live.
  always_ff @(posedge clk) begin
    if (enq_outer) side_mem_q[wr_ptr_q] <= SIDE_OUTER;
    if (enq_inner) side_mem_q[inner_wr_ptr] <= SIDE_INNER;
  end

  assign bus.req_valid     = req_valid;
  assign bus.req_side      = req_valid && (side_mem_q[rd_ptr_q] == SIDE_INNER);
  assign bus.pending_count = count_q;
  assign bus.head_eta      = (count_q != '0) ? timer_q : '0;
  assign bus.full          = (count_q == DEPTH_C);
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_gondola_request_queue.sv
// Directed checks of the gondola request queue with DEPTH=4, ARRIVAL_DELAY=10.
module tb_gondola_request_queue;

  logic clk;
  logic reset;
  int   vec_count;
  int   miscompares;

  gondola_request_queue_if bus ();

  gondola_request_queue #(.DEPTH(4), .ARRIVAL_DELAY(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic pulse(input logic o, input logic i);
    bus.outer_gondola_arrival_sw = o;
    bus.inner_gondola_arrival_sw = i;
    step(1);
    bus.outer_gondola_arrival_sw = 1'b0;
    bus.inner_gondola_arrival_sw = 1'b0;
    step(1);
  endtask

  // Waits (bounded) for a grant, records its side and accepts it.
  task automatic drain_one(output logic side, output bit ok);
    int k = 0;
    ok   = 1'b0;
    side = 1'b0;
    while (!bus.req_valid && k < 40) begin
      step(1);
      k++;
    end
    if (bus.req_valid) begin
      side = bus.req_side;
      ok   = 1'b1;
      bus.req_accept = 1'b1;
      step(1);
      bus.req_accept = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vec_count++; if (bus.pending_count !== 4'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", bus.pending_count); end
    vec_count++; if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", bus.req_valid); end
    vec_count++; if (bus.req_side !== 1'b0) begin miscompares++; $display("FAIL rst_side: got %b want 0", bus.req_side); end
    vec_count++; if (bus.head_eta !== 8'd0) begin miscompares++; $display("FAIL rst_eta: got %0d want 0", bus.head_eta); end
    vec_count++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %b want 0", bus.full); end
    vec_count++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
  endtask

  task automatic test_single();
    do_reset();
    step(2);
    bus.outer_gondola_arrival_sw = 1'b1;
    step(1);
    vec_count++; if (bus.pending_count !== 4'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", bus.pending_count); end
    vec_count++; if (bus.head_eta !== 8'd10) begin miscompares++; $display("FAIL single_eta_load: got %0d want 10", bus.head_eta); end
    step(4);
    vec_count++; if (bus.pending_count !== 4'd1) begin miscompares++; $display("FAIL single_held: got %0d want 1", bus.pending_count); end
    vec_count++; if (bus.head_eta !== 8'd6) begin miscompares++; $display("FAIL single_eta_dec: got %0d want 6", bus.head_eta); end
    bus.outer_gondola_arrival_sw = 1'b0;
    step(5);
    vec_count++; if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %b want 0", bus.req_valid); end
    step(1);
    vec_count++; if (bus.req_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", bus.req_valid); end
    vec_count++; if (bus.req_side !== 1'b0) begin miscompares++; $display("FAIL single_side: got %b want 0", bus.req_side); end
    step(3);
    vec_count++; if (bus.req_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid_hold: got %b want 1", bus.req_valid); end
    bus.req_accept = 1'b1;
    step(1);
    bus.req_accept = 1'b0;
    vec_count++; if (bus.pending_count !== 4'd0) begin miscompares++; $display("FAIL single_accept: got %0d want 0", bus.pending_count); end
    vec_count++; if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_clr: got %b want 0", bus.req_valid); end
  endtask

  task automatic test_both();
    do_reset();
    bus.outer_gondola_arrival_sw = 1'b1;
    bus.inner_gondola_arrival_sw = 1'b1;
    step(1);
    bus.outer_gondola_arrival_sw = 1'b0;
    bus.inner_gondola_arrival_sw = 1'b0;
    vec_count++; if (bus.pending_count !== 4'd2) begin miscompares++; $display("FAIL both_count: got %0d want 2", bus.pending_count); end
    step(10);
    vec_count++; if (bus.req_valid !== 1'b1 || bus.req_side !== 1'b0) begin miscompares++; $display("FAIL both_first: got valid=%b side=%b want valid=1 side=0", bus.req_valid, bus.req_side); end
    bus.req_accept = 1'b1;
    step(1);
    bus.req_accept = 1'b0;
    vec_count++; if (bus.pending_count !== 4'd1 || bus.head_eta !== 8'd10) begin miscompares++; $display("FAIL both_reload: got count=%0d eta=%0d want count=1 eta=10", bus.pending_count, bus.head_eta); end
    step(9);
    vec_count++; if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL both_second_early: got %b want 0", bus.req_valid); end
    step(1);
    vec_count++; if (bus.req_valid !== 1'b1 || bus.req_side !== 1'b1) begin miscompares++; $display("FAIL both_second: got valid=%b side=%b want valid=1 side=1", bus.req_valid, bus.req_side); end
    bus.req_accept = 1'b1;
    step(1);
    bus.req_accept = 1'b0;
    vec_count++; if (bus.pending_count !== 4'd0) begin miscompares++; $display("FAIL both_drain: got %0d want 0", bus.pending_count); end
  endtask

  task automatic test_overflow();
    logic s;
    bit   ok;
    bit   ok_all;
    do_reset();
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
    vec_count++; if (bus.pending_count !== 4'd4 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_fill: got count=%0d full=%b ovf=%b want 4 1 0", bus.pending_count, bus.full, bus.overflow); end
    pulse(1'b1, 1'b0);
    vec_count++; if (bus.pending_count !== 4'd4 || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_drop: got count=%0d full=%b ovf=%b want 4 1 1", bus.pending_count, bus.full, bus.overflow); end
    ok_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drain_one(s, ok);
      ok_all &= ok;
    end
    vec_count++; if (ok_all !== 1'b1) begin miscompares++; $display("FAIL ovf_drain_timeout: got %b want 1", ok_all); end
    vec_count++; if (bus.pending_count !== 4'd0 || bus.full !== 1'b0 || bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got count=%0d full=%b ovf=%b want 0 0 1", bus.pending_count, bus.full, bus.overflow); end
  endtask

  task automatic test_simultaneous();
    logic s [4];
    bit   ok;
    bit   ok_all;
    int   k;
    // Queue at 3, accept coincides with both switches rising.
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    k = 0;
    while (!bus.req_valid && k < 40) begin
      step(1);
      k++;
    end
    vec_count++; if (bus.req_valid !== 1'b1) begin miscompares++; $display("FAIL simul_wait_timeout: got %b want 1", bus.req_valid); end
    bus.outer_gondola_arrival_sw = 1'b1;
    bus.inner_gondola_arrival_sw = 1'b1;
    bus.req_accept = 1'b1;
    step(1);
    bus.outer_gondola_arrival_sw = 1'b0;
    bus.inner_gondola_arrival_sw = 1'b0;
    bus.req_accept = 1'b0;
    vec_count++; if (bus.pending_count !== 4'd4 || bus.overflow !== 1'b0) begin miscompares++; $display("FAIL simul_accept: got count=%0d ovf=%b want 4 0", bus.pending_count, bus.overflow); end
    ok_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drain_one(s[i], ok);
      ok_all &= ok;
    end
    vec_count++; if (ok_all !== 1'b1 || s[0] !== 1'b0 || s[3] !== 1'b1) begin miscompares++; $display("FAIL simul_order: got ok=%b first=%b last=%b want 1 0 1", ok_all, s[0], s[3]); end

    // Queue at 3, both rise, no accept: outer kept, inner dropped.
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    vec_count++; if (bus.pending_count !== 4'd4 || bus.overflow !== 1'b1) begin miscompares++; $display("FAIL simul_drop: got count=%0d ovf=%b want 4 1", bus.pending_count, bus.overflow); end
    ok_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drain_one(s[i], ok);
      ok_all &= ok;
    end
    vec_count++; if (ok_all !== 1'b1 || s[3] !== 1'b0) begin miscompares++; $display("FAIL simul_drop_side: got ok=%b last=%b want 1 0", ok_all, s[3]); end
  endtask

  task automatic test_reset_cases();
    int k;
    bus.outer_gondola_arrival_sw = 1'b1;
    do_reset();
    step(1);
    vec_count++; if (bus.pending_count !== 4'd0) begin miscompares++; $display("FAIL held_thru_reset: got %0d want 0", bus.pending_count); end
    step(2);
    vec_count++; if (bus.pending_count !== 4'd0) begin miscompares++; $display("FAIL held_later: got %0d want 0", bus.pending_count); end
    bus.outer_gondola_arrival_sw = 1'b0;
    step(1);
    bus.outer_gondola_arrival_sw = 1'b1;
    step(1);
    bus.outer_gondola_arrival_sw = 1'b0;
    vec_count++; if (bus.pending_count !== 4'd1) begin miscompares++; $display("FAIL rearm: got %0d want 1", bus.pending_count); end
    step(5);
    vec_count++; if (bus.head_eta !== 8'd5) begin miscompares++; $display("FAIL eta5: got %0d want 5", bus.head_eta); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    vec_count++; if ({bus.pending_count, bus.head_eta, bus.req_valid, bus.req_side, bus.full, bus.overflow} !== 16'd0) begin miscompares++; $display("FAIL mid_reset: got count=%0d eta=%0d valid=%b side=%b full=%b ovf=%b want all 0", bus.pending_count, bus.head_eta, bus.req_valid, bus.req_side, bus.full, bus.overflow); end
    // Reset coinciding with an accept discards the whole queue.
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    k = 0;
    while (!bus.req_valid && k < 40) begin
      step(1);
      k++;
    end
    bus.req_accept = 1'b1;
    reset = 1'b1;
    step(1);
    bus.req_accept = 1'b0;
    reset = 1'b0;
    step(1);
    vec_count++; if (bus.pending_count !== 4'd0 || bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL handshake_reset: got count=%0d valid=%b want 0 0", bus.pending_count, bus.req_valid); end
  endtask

  task automatic test_accept_idle();
    do_reset();
    bus.outer_gondola_arrival_sw = 1'b1;
    step(1);
    bus.outer_gondola_arrival_sw = 1'b0;
    step(6);
    vec_count++; if (bus.head_eta !== 8'd4) begin miscompares++; $display("FAIL idle_eta4: got %0d want 4", bus.head_eta); end
    bus.req_accept = 1'b1;
    step(1);
    bus.req_accept = 1'b0;
    vec_count++; if (bus.pending_count !== 4'd1 || bus.head_eta !== 8'd3) begin miscompares++; $display("FAIL idle_accept: got count=%0d eta=%0d want 1 3", bus.pending_count, bus.head_eta); end
    step(3);
    vec_count++; if (bus.req_valid !== 1'b1 || bus.head_eta !== 8'd0) begin miscompares++; $display("FAIL idle_continue: got valid=%b eta=%0d want 1 0", bus.req_valid, bus.head_eta); end
    bus.req_accept = 1'b1;
    step(1);
    bus.req_accept = 1'b0;
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.outer_gondola_arrival_sw = 1'b0;
    bus.inner_gondola_arrival_sw = 1'b0;
    bus.req_accept               = 1'b0;

    test_reset();
    test_single();
    test_both();
    test_overflow();
    test_simultaneous();
    test_reset_cases();
    test_accept_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/gondola_request_queue.md
GONDOLA_REQUEST_QUEUE -- requirements
Module: gondola_request_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set queue capacity in entries; legal range 2..8.
REQ-002 Parameter ARRIVAL_DELAY, default 10, SHALL set cycles from a request reaching queue head to gondola at gate; legal range 1..255.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  SHALL be synchronous, active-high reset.
REQ-005 Port outer_gondola_arrival_sw  input  1  SHALL be the level switch for a gondola signalling from the outer side; pre-synchronised.
REQ-006 Port inner_gondola_arrival_sw  input  1  SHALL be the level switch for a gondola signalling from the inner side; pre-synchronised.
REQ-007 Port req_accept  input  1  SHALL be the lock controller's acceptance of the head request.
REQ-008 Port req_valid  output  1  SHALL indicate the head gondola is at its gate.
REQ-009 Port req_side  output  1  SHALL give the head entry side: 0 outer, 1 inner; valid only with req_valid.
REQ-010 Port pending_count  output  4  SHALL give the number of queued entries, 0..DEPTH.
REQ-011 Port head_eta  output  8  SHALL give remaining head timer cycles; 0 when queue empty.
REQ-012 Port full  output  1  SHALL be high when pending_count == DEPTH.
REQ-013 Port overflow  output  1  SHALL be a sticky flag set when any request is dropped.

Function
REQ-014 A request SHALL be the rising edge of an arrival switch: level high this posedge, low at previous posedge.
REQ-015 A detected request SHALL be written at the posedge it is detected; a held-high switch SHALL generate exactly one request.
REQ-016 Entries SHALL dequeue in strict FIFO order.
REQ-017 Simultaneous outer and inner requests SHALL both be enqueued in one cycle, outer first.
REQ-018 With one free slot and simultaneous requests, outer SHALL be stored, inner dropped, and overflow set.
REQ-019 A request arriving while full and not dequeuing SHALL be dropped and SHALL set overflow.
REQ-020 Dequeue SHALL occur at a posedge where req_valid && req_accept; req_accept without req_valid SHALL have no effect.
REQ-021 Free-slot count for an enqueue SHALL include a slot released by a same-cycle dequeue.
REQ-022 The next pending_count SHALL be pending_count - deq + enq_outer + enq_inner, never exceeding DEPTH.
REQ-023 When an entry becomes head, the head timer SHALL load ARRIVAL_DELAY at that posedge. This covers enqueue into empty, or dequeue with entries remaining.
REQ-024 Each later posedge SHALL decrement the head timer by 1, saturating at 0.
REQ-025 req_valid SHALL equal (pending_count != 0) && (head timer == 0), decoded from registers only.
REQ-026 For a request detected at posedge N into an empty queue, req_valid SHALL first be high after posedge N+ARRIVAL_DELAY.
REQ-027 req_valid SHALL stay high, with req_side stable, until accepted.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 While reset is high at a posedge, the following SHALL clear to 0: pointers, pending_count, head timer, req_valid, req_side, head_eta, full, and overflow.
REQ-030 During reset, edge-detector history SHALL load the current switch levels, so no request is generated on the first post-reset cycle.
REQ-031 Reset mid-countdown or mid-handshake SHALL discard all entries with no partial dequeue.
REQ-032 Outside reset, only reset SHALL clear overflow.

Structure
REQ-033 Shared package lock_pkg SHALL hold SIDE_OUTER/SIDE_INNER constants and the DEPTH/ARRIVAL_DELAY defaults.
REQ-034 A sub-module rise_detect SHALL provide one-cycle rising-edge detection with reset-time history load; it SHALL be instantiated once per switch.
REQ-035 Storage SHALL be a DEPTH x 1-bit side register array; no memory macro.

Verification
REQ-036 Reset, outer switch rises at cycle 3 and is held 5 cycles -> single entry; req_valid high after cycle 13 with req_side=0; req_accept -> pending_count 0.
REQ-037 Both switches rise at the same cycle into an empty queue -> pending_count 2; first grant side 0; second grant side 1, valid exactly 10 cycles after first accept.
REQ-038 Five outer requests, DEPTH=4, no accepts -> pending_count 4, full=1, overflow=1; overflow stays 1 after drain.
REQ-039 Queue at 3, both switches rise, same-cycle accept -> pending_count 4, overflow=0; queue at 3, both rise, no accept -> pending_count 4, overflow=1.
REQ-040 Switch held high through reset release -> no entry created; reset at head_eta=5 -> all outputs 0 next cycle.
REQ-041 req_accept pulsed while req_valid=0 (head_eta=4) -> pending_count unchanged, countdown continues.
